// File: rtl/qos_pkg.sv
// rtl/qos_pkg.sv - shared widths, policy codes and saturating increment for the QoS queue bank
//
// Purpose : helpers shared by qos_fifo and qos_queue_bank.
// Contents: qsel_w/occ_w width helpers, drop-policy and scheduling-mode codes,
//           sat_inc saturating incrementer (callers cast the result to their width).
package qos_pkg;

    localparam int DROP_NEWEST_POLICY = 0;
    localparam int DROP_OLDEST_POLICY = 1;
    localparam int SCHED_STRICT       = 0;
    localparam int SCHED_ROUND_ROBIN  = 1;

    function automatic int qsel_w(input int num_queues);
        return (num_queues > 1) ? $clog2(num_queues) : 1;
    endfunction

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Holds at the all-ones value of a 'width'-bit counter instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/qos_fifo.sv
// rtl/qos_fifo.sv - shift-register FIFO with head at slot 0 and flat contents export
//
// Purpose : one QoS queue. Pop shifts every entry one slot toward the head; push writes
//           at the first free slot after any pop. Push+pop on a full queue is legal.
// Ports   : clk_i, rst_i (async, active-high), push_i, pop_i, din_i,
//           full_o, empty_o, occ_o (fill level), data_o (slot i at [i*PAYLOAD_W +: PAYLOAD_W]).
module qos_fifo
    import qos_pkg::*;
#(
    parameter int DEPTH     = 6,
    parameter int PAYLOAD_W = 2,
    parameter int OCC_W     = occ_w(DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [PAYLOAD_W-1:0]         din_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [OCC_W-1:0]             occ_o,
    output logic [DEPTH*PAYLOAD_W-1:0]   data_o
);

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [PAYLOAD_W-1:0] mem_d [DEPTH];
    logic [OCC_W-1:0]     occ_q;
    logic [OCC_W-1:0]     occ_d;
    logic [OCC_W-1:0]     occ_mid;
    logic                 do_pop;
    logic                 do_push;

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        // A full queue only takes a push when the same cycle frees a slot.
        do_push = push_i && (!full_o || do_pop);
        mem_d   = mem_q;
        occ_mid = occ_q;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
            occ_mid        = occ_q - OCC_W'(1);
        end
        occ_d = occ_mid;
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ_mid == OCC_W'(i)) begin
                    mem_d[i] = din_i;
                end
            end
            occ_d = occ_mid + OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            mem_q <= mem_d;
        end
    end

    always_comb begin
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            data_o[i*PAYLOAD_W +: PAYLOAD_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/qos_queue_bank.sv
// rtl/qos_queue_bank.sv - multi-queue QoS packet buffer with drop policy and periodic scheduler
//
// Purpose : steers {queue, payload} packets into NUM_QUEUES FIFOs, drops on overflow
//           (oldest or newest), and dequeues one packet every OUT_PERIOD cycles under
//           strict priority or round-robin scheduling.
// Ports   : clock_50, reset (async, active-high), pkt_valid, pkt_data,
//           received_cnt/dropped_cnt/output_cnt (per-queue saturating counters),
//           occupancy, queue_data (head at slot 0), out_valid (1-cycle pulse), out_packet.
module qos_queue_bank
    import qos_pkg::*;
#(
    parameter int NUM_QUEUES  = 4,
    parameter int DEPTH       = 6,
    parameter int PAYLOAD_W   = 2,
    parameter int CNT_W       = 12,
    parameter int OUT_PERIOD  = 150000000,
    parameter int DROP_OLDEST = 1,
    parameter int SCHED_RR    = 0,
    localparam int QSEL_W     = qsel_w(NUM_QUEUES),
    localparam int OCC_W      = occ_w(DEPTH),
    localparam int PKT_W      = QSEL_W + PAYLOAD_W
) (
    input  logic                                clock_50,
    input  logic                                reset,
    input  logic                                pkt_valid,
    input  logic [PKT_W-1:0]                    pkt_data,
    output logic [NUM_QUEUES*CNT_W-1:0]         received_cnt,
    output logic [NUM_QUEUES*CNT_W-1:0]         dropped_cnt,
    output logic [NUM_QUEUES*CNT_W-1:0]         output_cnt,
    output logic [NUM_QUEUES*OCC_W-1:0]         occupancy,
    output logic [NUM_QUEUES*DEPTH*PAYLOAD_W-1:0] queue_data,
    output logic                                out_valid,
    output logic [PKT_W-1:0]                    out_packet
);

    logic [QSEL_W-1:0]    tgt;
    logic [PAYLOAD_W-1:0] payload;
    logic [31:0]          timer_q, timer_d;
    logic                 tick;
    logic [QSEL_W-1:0]    rr_q, rr_d;
    logic [QSEL_W-1:0]    sel;
    logic [QSEL_W-1:0]    idx;
    logic                 found;
    logic                 deq;
    logic                 out_valid_q;
    logic [PKT_W-1:0]     out_packet_q;

    logic [NUM_QUEUES-1:0] q_full, q_empty, q_hit, q_deq, q_drop, q_pop;
    logic [PAYLOAD_W-1:0]  q_head [NUM_QUEUES];
    logic [CNT_W-1:0]      rcv_q [NUM_QUEUES];
    logic [CNT_W-1:0]      rcv_d [NUM_QUEUES];
    logic [CNT_W-1:0]      drp_q [NUM_QUEUES];
    logic [CNT_W-1:0]      drp_d [NUM_QUEUES];
    logic [CNT_W-1:0]      outc_q [NUM_QUEUES];
    logic [CNT_W-1:0]      outc_d [NUM_QUEUES];

    assign tgt     = pkt_data[PKT_W-1 -: QSEL_W];
    assign payload = pkt_data[PAYLOAD_W-1:0];

    assign tick    = (timer_q == 32'(OUT_PERIOD - 1));
    assign timer_d = tick ? '0 : timer_q + 32'd1;

    // Selection looks only at pre-cycle emptiness, so a packet arriving this cycle
    // is never dequeued in the same cycle.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        if (SCHED_RR == SCHED_ROUND_ROBIN) begin
            // Walk offsets downward so the nearest non-empty queue after rr_q wins.
            for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
                idx = rr_q + QSEL_W'(k);
                if (!q_empty[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (!q_empty[i]) begin
                    sel   = QSEL_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign deq  = tick && found;
    assign rr_d = (deq && (SCHED_RR == SCHED_ROUND_ROBIN)) ? sel + QSEL_W'(1) : rr_q;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), CNT_W));
    endfunction

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            q_hit[q]  = pkt_valid && (tgt == QSEL_W'(q));
            q_deq[q]  = deq && (sel == QSEL_W'(q));
            // A same-cycle dequeue frees the slot, so the push is not a drop.
            q_drop[q] = q_hit[q] && q_full[q] && !q_deq[q];
            q_pop[q]  = q_deq[q] || (q_drop[q] && (DROP_OLDEST == DROP_OLDEST_POLICY));
            rcv_d[q]  = q_hit[q]  ? bump(rcv_q[q])  : rcv_q[q];
            drp_d[q]  = q_drop[q] ? bump(drp_q[q])  : drp_q[q];
            outc_d[q] = q_deq[q]  ? bump(outc_q[q]) : outc_q[q];
        end
    end

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
        logic [DEPTH*PAYLOAD_W-1:0] data;

        qos_fifo #(
            .DEPTH     (DEPTH),
            .PAYLOAD_W (PAYLOAD_W),
            .OCC_W     (OCC_W)
        ) u_fifo (
            .clk_i   (clock_50),
            .rst_i   (reset),
            .push_i  (q_hit[g]),
            .pop_i   (q_pop[g]),
            .din_i   (payload),
            .full_o  (q_full[g]),
            .empty_o (q_empty[g]),
            .occ_o   (occupancy[g*OCC_W +: OCC_W]),
            .data_o  (data)
        );

        assign queue_data[g*DEPTH*PAYLOAD_W +: DEPTH*PAYLOAD_W] = data;
        assign q_head[g]                       = data[PAYLOAD_W-1:0];
        assign received_cnt[g*CNT_W +: CNT_W]  = rcv_q[g];
        assign dropped_cnt[g*CNT_W +: CNT_W]   = drp_q[g];
        assign output_cnt[g*CNT_W +: CNT_W]    = outc_q[g];
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            timer_q      <= '0;
            rr_q         <= '0;
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                rcv_q[q]  <= '0;
                drp_q[q]  <= '0;
                outc_q[q] <= '0;
            end
        end else begin
            timer_q     <= timer_d;
            rr_q        <= rr_d;
            out_valid_q <= deq;
            if (deq) begin
                out_packet_q <= {sel, q_head[sel]};
            end
            rcv_q  <= rcv_d;
            drp_q  <= drp_d;
            outc_q <= outc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;

endmodule

// File: tb/tb_qos_queue_bank.sv
// tb/tb_qos_queue_bank.sv - scoreboard bench for qos_queue_bank (strict/drop-oldest and rr/drop-newest)
module tb_qos_queue_bank;

    localparam int NQ    = 4;
    localparam int DEPTH = 6;
    localparam int PW    = 2;
    localparam int OW    = 3;
    localparam int CWA   = 12;
    localparam int CWB   = 3;
    localparam int PER   = 4;

    logic clk = 1'b0;
    logic reset;
    logic pkt_valid;
    logic [3:0] pkt_data;

    logic [NQ*CWA-1:0]      rcv_a, drp_a, outc_a;
    logic [NQ*CWB-1:0]      rcv_b, drp_b, outc_b;
    logic [NQ*OW-1:0]       occ_a, occ_b;
    logic [NQ*DEPTH*PW-1:0] qd_a, qd_b;
    logic                   ov_a, ov_b;
    logic [3:0]             op_a, op_b;

    always #5 clk = ~clk;

    qos_queue_bank #(
        .NUM_QUEUES(NQ), .DEPTH(DEPTH), .PAYLOAD_W(PW), .CNT_W(CWA),
        .OUT_PERIOD(PER), .DROP_OLDEST(1), .SCHED_RR(0)
    ) u_dut_a (
        .clock_50(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .received_cnt(rcv_a), .dropped_cnt(drp_a), .output_cnt(outc_a),
        .occupancy(occ_a), .queue_data(qd_a), .out_valid(ov_a), .out_packet(op_a)
    );

    qos_queue_bank #(
        .NUM_QUEUES(NQ), .DEPTH(DEPTH), .PAYLOAD_W(PW), .CNT_W(CWB),
        .OUT_PERIOD(PER), .DROP_OLDEST(0), .SCHED_RR(1)
    ) u_dut_b (
        .clock_50(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .received_cnt(rcv_b), .dropped_cnt(drp_b), .output_cnt(outc_b),
        .occupancy(occ_b), .queue_data(qd_b), .out_valid(ov_b), .out_packet(op_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = instance A, 1 = instance B.
    int mq [2][NQ][$];
    int m_rcv [2][NQ];
    int m_drp [2][NQ];
    int m_out [2][NQ];
    int m_timer [2];
    int m_rr [2];
    int sb [2][$];
    int obs_b [$];
    int pulses_b = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int inst);
        int mx;
        mx = (inst == 0) ? (1 << CWA) - 1 : (1 << CWB) - 1;
        return (v >= mx) ? v : v + 1;
    endfunction

    task automatic model_reset(input int inst);
        for (int q = 0; q < NQ; q++) begin
            mq[inst][q].delete();
            m_rcv[inst][q] = 0;
            m_drp[inst][q] = 0;
            m_out[inst][q] = 0;
        end
        m_timer[inst] = 0;
        m_rr[inst]    = 0;
        sb[inst].delete();
    endtask

    task automatic model_cycle(input int inst, input bit v, input int tq, input int p);
        bit tick;
        int sel;
        int h;
        int idx;
        tick = (m_timer[inst] == PER - 1);
        m_timer[inst] = tick ? 0 : m_timer[inst] + 1;
        sel = -1;
        if (tick) begin
            if (inst == 0) begin
                for (int i = NQ - 1; i >= 0; i--)
                    if (sel < 0 && mq[inst][i].size() > 0) sel = i;
            end else begin
                for (int k = 0; k < NQ; k++) begin
                    idx = (m_rr[inst] + k) % NQ;
                    if (sel < 0 && mq[inst][idx].size() > 0) sel = idx;
                end
            end
        end
        if (sel >= 0) begin
            h = mq[inst][sel].pop_front();
            sb[inst].push_back(sel * 4 + h);
            m_out[inst][sel] = sat(m_out[inst][sel], inst);
            if (inst == 1) m_rr[inst] = (sel + 1) % NQ;
        end
        if (v) begin
            m_rcv[inst][tq] = sat(m_rcv[inst][tq], inst);
            if (mq[inst][tq].size() < DEPTH) begin
                mq[inst][tq].push_back(p);
            end else begin
                m_drp[inst][tq] = sat(m_drp[inst][tq], inst);
                if (inst == 0) begin
                    void'(mq[inst][tq].pop_front());
                    mq[inst][tq].push_back(p);
                end
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input int q, input int p);
        pkt_valid = v;
        pkt_data  = {2'(q), 2'(p)};
        model_cycle(0, v, q, p);
        model_cycle(1, v, q, p);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0);
    endtask

    task automatic check_stats(input int inst);
        string n;
        int g;
        int e;
        n = (inst == 0) ? "A" : "B";
        for (int q = 0; q < NQ; q++) begin
            g = (inst == 0) ? int'(occ_a[q*OW +: OW]) : int'(occ_b[q*OW +: OW]);
            check_eq($sformatf("%s occupancy q%0d", n, q), g, mq[inst][q].size());
            g = (inst == 0) ? int'(rcv_a[q*CWA +: CWA]) : int'(rcv_b[q*CWB +: CWB]);
            check_eq($sformatf("%s received q%0d", n, q), g, m_rcv[inst][q]);
            g = (inst == 0) ? int'(drp_a[q*CWA +: CWA]) : int'(drp_b[q*CWB +: CWB]);
            check_eq($sformatf("%s dropped q%0d", n, q), g, m_drp[inst][q]);
            g = (inst == 0) ? int'(outc_a[q*CWA +: CWA]) : int'(outc_b[q*CWB +: CWB]);
            check_eq($sformatf("%s output q%0d", n, q), g, m_out[inst][q]);
            for (int s = 0; s < DEPTH; s++) begin
                g = (inst == 0) ? int'(qd_a[(q*DEPTH+s)*PW +: PW]) : int'(qd_b[(q*DEPTH+s)*PW +: PW]);
                e = (s < mq[inst][q].size()) ? mq[inst][q][s] : 0;
                check_eq($sformatf("%s data q%0d s%0d", n, q, s), g, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ov_a) begin
                if (sb[0].size() == 0) check_eq("A spurious out_valid", int'(ov_a), 0);
                else check_eq("A out_packet", int'(op_a), sb[0].pop_front());
            end
            if (ov_b) begin
                pulses_b++;
                obs_b.push_back(int'(op_b));
                if (sb[1].size() == 0) check_eq("B spurious out_valid", int'(ov_b), 0);
                else check_eq("B out_packet", int'(op_b), sb[1].pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int p0;
        reset     = 1'b1;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge clk);
        check_eq("A out_valid reset", int'(ov_a), 0);
        check_eq("A out_packet reset", int'(op_a), 0);
        check_eq("B out_valid reset", int'(ov_b), 0);
        check_stats(0);
        check_stats(1);
        reset = 1'b0;

        // Three pushes into q2.
        step(1, 2, 1); step(1, 2, 2); step(1, 2, 3);
        check_eq("A occ q2 after 3", int'(occ_a[8:6]), 3);
        check_eq("A rcv q2 after 3", int'(rcv_a[35:24]), 3);
        check_eq("A q2 slot0", int'(qd_a[25:24]), 1);
        check_eq("A q2 slot1", int'(qd_a[27:26]), 2);
        check_eq("A q2 slot2", int'(qd_a[29:28]), 3);
        check_stats(0);
        check_stats(1);

        // Overflow q1 with eight back-to-back pushes.
        idle(1);
        for (int i = 0; i < 8; i++) step(1, 1, i % 4);
        check_eq("A drop q1", int'(drp_a[23:12]), 2);
        check_eq("A occ q1 full", int'(occ_a[5:3]), 6);
        check_eq("A q1 head third payload", int'(qd_a[13:12]), 2);
        check_stats(0);
        check_stats(1);

        // Strict priority: q3 drains before q0.
        idle(40);
        guard = 0;
        while (m_timer[0] != 0 && guard < 8) begin idle(1); guard++; end
        step(1, 0, 1); step(1, 0, 2); step(1, 3, 3); step(1, 3, 0);
        idle(16);
        check_eq("A output q3", int'(outc_a[47:36]), 2);
        check_stats(0);
        check_stats(1);

        // Round-robin from pointer 0 after reset, then idle periods with no pulse.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset(0);
        model_reset(1);
        obs_b.delete();
        idle(3);
        step(1, 0, 1); step(1, 1, 2); step(1, 2, 3); step(1, 3, 1);
        idle(16);
        check_eq("B rr pulse count", obs_b.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < obs_b.size()) check_eq($sformatf("B rr order %0d", k), obs_b[k] >> 2, k);
        p0 = pulses_b;
        idle(12);
        check_eq("B idle pulses", pulses_b - p0, 0);
        check_stats(0);
        check_stats(1);

        // Fill q0, then push into it on the dequeue cycle.
        guard = 0;
        while (!(mq[0][0].size() == DEPTH && mq[1][0].size() == DEPTH && m_timer[0] == PER - 1)
               && guard < 40) begin
            step(1, 0, guard % 4);
            guard++;
        end
        step(1, 0, 2);
        idle(1);
        check_eq("A occ q0 stays full", int'(occ_a[2:0]), 6);
        check_eq("B rcv q0 saturated", int'(rcv_b[2:0]), 7);
        check_stats(0);
        check_stats(1);

        // Random traffic.
        for (int c = 0; c < 200; c++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3));
            if (c % 50 == 49) begin
                check_stats(0);
                check_stats(1);
            end
        end

        // Asynchronous reset in the middle of traffic.
        step(1, 0, 1); step(1, 1, 2); step(1, 2, 3);
        #2;
        reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check_eq("A out_valid async reset", int'(ov_a), 0);
        check_eq("A out_packet async reset", int'(op_a), 0);
        check_eq("B out_valid async reset", int'(ov_b), 0);
        check_eq("B out_packet async reset", int'(op_b), 0);
        check_stats(0);
        check_stats(1);
        pkt_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 3, 2); step(1, 1, 1);
        idle(10);
        check_stats(0);
        check_stats(1);
        check_eq("A pending pulses", sb[0].size(), 0);
        check_eq("B pending pulses", sb[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
